// File: rtl/m_axis_rc_adapt_128b.sv
// UltraScale+ PCIe RC AXI-Stream (128b) to legacy 3DW completion TLP beats, with a 2-entry skid buffer.
// Define M_AXIS_RC_ADAPT_LEN_CHECK_EN to build the payload length checker (rc_len_err / rc_len_err_cnt).
module m_axis_rc_adapt_128b #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a,
    input  logic [3:0]            m_axis_rc_tkeep_a,
    input  logic                  m_axis_rc_tlast_a,
    input  logic [74:0]           m_axis_rc_tuser_a,
    input  logic                  m_axis_rc_tvalid_a,
    output logic                  m_axis_rc_tready_a,
    output logic [DATA_WIDTH-1:0] m_axis_rc_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep,
    output logic                  m_axis_rc_tlast,
    output logic                  m_axis_rc_tuser,
    output logic                  m_axis_rc_tvalid,
    input  logic                  m_axis_rc_tready,
    output logic                  rc_len_err,
    output logic [15:0]           rc_len_err_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            keep;
        logic                  last;
        logic                  disc;
    } rc_beat_t;

    rc_beat_t    ent [2];
    rc_beat_t    head, in_beat;
    logic [1:0]  cnt, cnt_nxt;
    logic        wr_ptr, rd_ptr;
    logic        sof_in, sof_out;
    logic        push, pop;
    logic [10:0] dw_cnt;
    logic [31:0] hdr_dw0, hdr_dw1, hdr_dw2;
    logic        unused_tuser;

    assign push   = m_axis_rc_tvalid_a & m_axis_rc_tready_a;
    assign pop    = m_axis_rc_tvalid & m_axis_rc_tready;
    assign dw_cnt = m_axis_rc_tdata_a[42:32];
    assign unused_tuser = ^{m_axis_rc_tuser_a[74:43], m_axis_rc_tuser_a[41:0]};

    // Descriptor and completion header share DW0..DW2; DW3 is already payload.
    always_comb begin
        hdr_dw0 = {(dw_cnt != 11'd0) ? 8'h4A : 8'h0A, 1'b0, m_axis_rc_tdata_a[91:89], 5'b0,
                   m_axis_rc_tdata_a[46], m_axis_rc_tdata_a[93:92], 2'b0, dw_cnt[9:0]};
        hdr_dw1 = {m_axis_rc_tdata_a[87:72], m_axis_rc_tdata_a[45:43], 1'b0, m_axis_rc_tdata_a[27:16]};
        hdr_dw2 = {m_axis_rc_tdata_a[63:48], m_axis_rc_tdata_a[71:64], 1'b0, m_axis_rc_tdata_a[6:0]};
        in_beat.data = m_axis_rc_tdata_a;
        if (sof_in)
            in_beat.data = {m_axis_rc_tdata_a[127:96], hdr_dw2, hdr_dw1, hdr_dw0};
        in_beat.keep = m_axis_rc_tkeep_a;
        in_beat.last = m_axis_rc_tlast_a;
        in_beat.disc = m_axis_rc_tuser_a[42];
    end

    always_comb cnt_nxt = cnt + 2'(push) - 2'(pop);

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            cnt                <= 2'd0;
            wr_ptr             <= 1'b0;
            rd_ptr             <= 1'b0;
            sof_in             <= 1'b1;
            sof_out            <= 1'b1;
            m_axis_rc_tready_a <= 1'b0;
            for (int i = 0; i < 2; i++) ent[i] <= '0;
        end else begin
            cnt                <= cnt_nxt;
            m_axis_rc_tready_a <= (cnt_nxt < 2'd2);
            if (push) begin
                ent[wr_ptr] <= in_beat;
                wr_ptr      <= ~wr_ptr;
                sof_in      <= m_axis_rc_tlast_a;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                sof_out <= m_axis_rc_tlast;
            end
        end
    end

    assign head             = ent[rd_ptr];
    assign m_axis_rc_tvalid = (cnt != 2'd0);
    assign m_axis_rc_tdata  = head.data;
    assign m_axis_rc_tlast  = head.last;
    assign m_axis_rc_tuser  = head.disc & head.last & m_axis_rc_tvalid;

    for (genvar g = 0; g < 4; g++) begin : g_keep
        assign m_axis_rc_tkeep[4*g +: 4] = {4{head.keep[g]}};
    end

    // A header beat leaving toward the core must carry at least the three header dwords.
    a_hdr_keep: assert property (@(posedge user_clk) disable iff (user_reset)
        (m_axis_rc_tvalid && sof_out) |-> (&m_axis_rc_tkeep[11:0]));

`ifdef M_AXIS_RC_ADAPT_LEN_CHECK_EN
    logic [10:0] exp_dw, rcv_dw, beat_dw, tot_dw, want_dw;

    // The first beat's keep includes the 3 descriptor dwords, hence the -3.
    always_comb begin
        beat_dw = 11'(m_axis_rc_tkeep_a[0]) + 11'(m_axis_rc_tkeep_a[1])
                + 11'(m_axis_rc_tkeep_a[2]) + 11'(m_axis_rc_tkeep_a[3]);
        tot_dw  = sof_in ? beat_dw - 11'd3 : rcv_dw + beat_dw;
        want_dw = sof_in ? dw_cnt : exp_dw;
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            exp_dw         <= 11'd0;
            rcv_dw         <= 11'd0;
            rc_len_err     <= 1'b0;
            rc_len_err_cnt <= 16'd0;
        end else begin
            rc_len_err <= 1'b0;
            if (push) begin
                if (sof_in) exp_dw <= dw_cnt;
                rcv_dw <= tot_dw;
                if (m_axis_rc_tlast_a && (tot_dw != want_dw)) begin
                    rc_len_err <= 1'b1;
                    if (rc_len_err_cnt != 16'hFFFF) rc_len_err_cnt <= rc_len_err_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign rc_len_err     = 1'b0;
    assign rc_len_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_m_axis_rc_adapt_128b.sv
// Directed bench for m_axis_rc_adapt_128b: header rewrite, keep expansion, backpressure, length check, reset.
module tb_m_axis_rc_adapt_128b;

`ifdef M_AXIS_RC_ADAPT_LEN_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic         user_clk = 1'b0;
    logic         user_reset;
    logic [127:0] tdata_a;
    logic [3:0]   tkeep_a;
    logic         tlast_a;
    logic [74:0]  tuser_a;
    logic         tvalid_a;
    logic         tready_a;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast, tuser, tvalid, tready;
    logic         len_err;
    logic [15:0]  len_err_cnt;
    logic         bp_en = 1'b0;
    logic         bp_tog = 1'b0;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         u;
    } obeat_t;

    obeat_t oq [$];
    int     tests = 0;
    int     fails = 0;
    int     err_pulses = 0;

    always #5 user_clk = ~user_clk;
    always @(posedge user_clk) bp_tog <= ~bp_tog;
    assign tready = bp_en ? bp_tog : 1'b1;

    m_axis_rc_adapt_128b dut (
        .user_clk           (user_clk),
        .user_reset         (user_reset),
        .m_axis_rc_tdata_a  (tdata_a),
        .m_axis_rc_tkeep_a  (tkeep_a),
        .m_axis_rc_tlast_a  (tlast_a),
        .m_axis_rc_tuser_a  (tuser_a),
        .m_axis_rc_tvalid_a (tvalid_a),
        .m_axis_rc_tready_a (tready_a),
        .m_axis_rc_tdata    (tdata),
        .m_axis_rc_tkeep    (tkeep),
        .m_axis_rc_tlast    (tlast),
        .m_axis_rc_tuser    (tuser),
        .m_axis_rc_tvalid   (tvalid),
        .m_axis_rc_tready   (tready),
        .rc_len_err         (len_err),
        .rc_len_err_cnt     (len_err_cnt)
    );

    always @(negedge user_clk) begin
        if (tvalid && tready) oq.push_back('{d: tdata, k: tkeep, l: tlast, u: tuser});
        if (len_err) err_pulses++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_desc(input logic [10:0] dwc, input logic [12:0] bc,
                                             input logic [2:0] st, input logic [7:0] tag,
                                             input logic [6:0] la, input logic [15:0] req,
                                             input logic [15:0] cpl, input logic [2:0] tc,
                                             input logic [1:0] attr, input logic ep,
                                             input logic [31:0] dw3);
        logic [127:0] d;
        d        = '0;
        d[6:0]   = la;
        d[15:12] = 4'hF;  // error-code field, must not leak into the header
        d[28:16] = bc;
        d[30]    = 1'b1;
        d[42:32] = dwc;
        d[45:43] = st;
        d[46]    = ep;
        d[63:48] = req;
        d[71:64] = tag;
        d[87:72] = cpl;
        d[91:89] = tc;
        d[93:92] = attr;
        d[127:96] = dw3;
        return d;
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic l, input logic disc);
        int   t = 0;
        logic acc = 1'b0;
        tdata_a     = d;
        tkeep_a     = k;
        tlast_a     = l;
        tuser_a     = '0;
        tuser_a[42] = disc;
        tvalid_a    = 1'b1;
        while (!acc && t < 50) begin
            @(negedge user_clk);
            acc = tready_a;
            t++;
        end
        check("send_accept", acc, 1'b1);
        @(posedge user_clk); #1;
        tvalid_a = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (oq.size() < n && t < 3000) begin
            @(negedge user_clk);
            t++;
        end
        check("wait_out_count", oq.size(), n);
        @(posedge user_clk); #1;
    endtask

    initial begin
        logic [127:0] bpd [4];
        int   occ, max_occ, nsent, nlast;
        logic push, pop;

        user_reset = 1'b1;
        tdata_a = '0; tkeep_a = '0; tlast_a = 1'b0; tuser_a = '0; tvalid_a = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tready_a", tready_a, 1'b0);
        check("rst_tuser", tuser, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_len_err_cnt", len_err_cnt, 16'd0);
        user_reset = 1'b0;
        @(posedge user_clk); #1;
        check("rst_rel_tready_a", tready_a, 1'b1);

        // 1-DW read completion
        send_beat(mk_desc(11'd1, 13'd4, 3'd0, 8'h12, 7'h04, 16'hABCD, 16'h0100, 3'd0, 2'd0, 1'b0,
                          32'hDEADBEEF), 4'hF, 1'b1, 1'b0);
        check("c1_latency_valid", tvalid, 1'b1);
        check("c1_latency_len_err", len_err, 1'b0);
        wait_out(1);
        check("c1_dw0", oq[0].d[31:0], 32'h4A000001);
        check("c1_dw1", oq[0].d[63:32], 32'h01000004);
        check("c1_dw2", oq[0].d[95:64], 32'hABCD1204);
        check("c1_tag", oq[0].d[79:72], 8'h12);
        check("c1_dw3", oq[0].d[127:96], 32'hDEADBEEF);
        check("c1_keep", oq[0].k, 16'hFFFF);
        check("c1_last", oq[0].l, 1'b1);
        check("c1_user", oq[0].u, 1'b0);
        check("c1_err_pulses", err_pulses, 0);
        oq.delete();

        // 1024-DW completion, byte_count 4096
        send_beat(mk_desc(11'd1024, 13'd4096, 3'd0, 8'h34, 7'h00, 16'h1111, 16'h2222, 3'd0, 2'd0, 1'b0,
                          32'h0), 4'hF, 1'b0, 1'b0);
        for (int i = 1; i < 256; i++) send_beat({4{32'(i)}}, 4'hF, 1'b0, 1'b0);
        send_beat({4{32'd256}}, 4'h7, 1'b1, 1'b0);
        wait_out(257);
        check("big_dw0", oq[0].d[31:0], 32'h4A000000);
        check("big_dw0_len", oq[0].d[9:0], 10'd0);
        check("big_dw1", oq[0].d[63:32], 32'h22220000);
        check("big_dw1_bc", oq[0].d[43:32], 12'd0);
        check("big_dw2", oq[0].d[95:64], 32'h11113400);
        check("big_mid_data", oq[100].d, {4{32'd100}});
        check("big_mid_keep", oq[100].k, 16'hFFFF);
        check("big_last_keep", oq[256].k, 16'h0FFF);
        check("big_last_data", oq[256].d, {4{32'd256}});
        nlast = 0;
        foreach (oq[i]) if (oq[i].l) nlast++;
        check("big_nlast", nlast, 1);
        check("big_last_flag", oq[256].l, 1'b1);
        check("big_err_pulses", err_pulses, 0);
        oq.delete();

        // Completion without data, non-zero TC/attr/EP
        send_beat(mk_desc(11'd0, 13'd0, 3'b001, 8'h56, 7'h7F, 16'h3333, 16'h4444, 3'd5, 2'd2, 1'b1,
                          32'h0), 4'h7, 1'b1, 1'b0);
        wait_out(1);
        check("cpl_fmt", oq[0].d[31:24], 8'h0A);
        check("cpl_dw0", oq[0].d[31:0], 32'h0A506000);
        check("cpl_status", oq[0].d[47:45], 3'b001);
        check("cpl_dw1", oq[0].d[63:32], 32'h44442000);
        check("cpl_dw2", oq[0].d[95:64], 32'h3333567F);
        check("cpl_keep", oq[0].k, 16'h0FFF);
        check("cpl_err_pulses", err_pulses, 0);
        oq.delete();

        // Backpressure: core ready toggles every cycle during a 4-beat completion
        bpd[0] = mk_desc(11'd13, 13'd52, 3'd0, 8'h77, 7'h00, 16'h0000, 16'h0000, 3'd0, 2'd0, 1'b0,
                         32'h11111111);
        bpd[1] = 128'h2222_0001_2222_0002_2222_0003_2222_0004;
        bpd[2] = 128'h3333_0001_3333_0002_3333_0003_3333_0004;
        bpd[3] = 128'h4444_0001_4444_0002_4444_0003_4444_0004;
        bp_en = 1'b1;
        occ = 0; max_occ = 0; nsent = 0;
        for (int cyc = 0; cyc < 60 && (nsent < 4 || occ != 0); cyc++) begin
            tvalid_a = (nsent < 4);
            if (nsent < 4) begin
                tdata_a = bpd[nsent];
                tkeep_a = 4'hF;
                tlast_a = (nsent == 3);
                tuser_a = '0;
            end
            @(negedge user_clk);
            check("bp_tready_a", tready_a, occ < 2);
            check("bp_tvalid", tvalid, occ != 0);
            push = tvalid_a && tready_a;
            pop  = tvalid && tready;
            occ  = occ + int'(push) - int'(pop);
            if (occ > max_occ) max_occ = occ;
            if (push) nsent++;
            @(posedge user_clk); #1;
        end
        tvalid_a = 1'b0;
        bp_en = 1'b0;
        check("bp_filled", max_occ, 2);
        check("bp_count", oq.size(), 4);
        if (oq.size() == 4) begin
            check("bp_b0_dw0", oq[0].d[31:0], 32'h4A00000D);
            check("bp_b0_dw1", oq[0].d[63:32], 32'h00000034);
            check("bp_b0_dw2", oq[0].d[95:64], 32'h00007700);
            check("bp_b0_dw3", oq[0].d[127:96], 32'h11111111);
            check("bp_b1", oq[1].d, bpd[1]);
            check("bp_b2", oq[2].d, bpd[2]);
            check("bp_b3", oq[3].d, bpd[3]);
            check("bp_b3_last", oq[3].l, 1'b1);
        end
        check("bp_err_pulses", err_pulses, 0);
        oq.delete();
        @(posedge user_clk); #1;

        // Length mismatch: dword_count 8, only 5 DW of payload
        send_beat(mk_desc(11'd8, 13'd32, 3'd0, 8'h99, 7'h00, 16'h0000, 16'h0000, 3'd0, 2'd0, 1'b0,
                          32'hCAFE0001), 4'hF, 1'b0, 1'b0);
        send_beat(128'h5, 4'hF, 1'b1, 1'b0);
        check("mm_pulse", len_err, CHK);
        @(posedge user_clk); #1;
        check("mm_pulse_end", len_err, 1'b0);
        check("mm_cnt", len_err_cnt, {15'd0, CHK});
        wait_out(2);
        check("mm_err_pulses", err_pulses, int'(CHK));
        oq.delete();

        // Reset mid-packet, then a clean completion with discontinue on its last beat
        send_beat(mk_desc(11'd13, 13'd52, 3'd0, 8'h21, 7'h00, 16'h0000, 16'h0000, 3'd0, 2'd0, 1'b0,
                          32'h0), 4'hF, 1'b0, 1'b0);
        send_beat(128'h1, 4'hF, 1'b0, 1'b0);
        user_reset = 1'b1;
        @(posedge user_clk); #1;
        check("mr_tvalid", tvalid, 1'b0);
        check("mr_tready_a", tready_a, 1'b0);
        check("mr_tuser", tuser, 1'b0);
        check("mr_len_err_cnt", len_err_cnt, 16'd0);
        user_reset = 1'b0;
        oq.delete();
        @(posedge user_clk); #1;
        check("mr_rel_tready_a", tready_a, 1'b1);
        send_beat(mk_desc(11'd5, 13'd20, 3'd0, 8'h5A, 7'h10, 16'hBEEF, 16'hCAFE, 3'd0, 2'd0, 1'b0,
                          32'hAAAA5555), 4'hF, 1'b0, 1'b0);
        send_beat(128'h9999_8888_7777_6666_5555_4444_3333_2222, 4'hF, 1'b1, 1'b1);
        wait_out(2);
        check("mr_b0_dw0", oq[0].d[31:0], 32'h4A000005);
        check("mr_b0_dw1", oq[0].d[63:32], 32'hCAFE0014);
        check("mr_b0_dw2", oq[0].d[95:64], 32'hBEEF5A10);
        check("mr_b0_user", oq[0].u, 1'b0);
        check("mr_b1_user", oq[1].u, 1'b1);
        check("mr_b1_last", oq[1].l, 1'b1);
        check("mr_b1_data", oq[1].d, 128'h9999_8888_7777_6666_5555_4444_3333_2222);
        check("mr_err_pulses", err_pulses, int'(CHK));
        check("mr_tuser_idle", tuser, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
